// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - operand/result bundle for serial_addsub (acc member present with SERIAL_ADDSUB_ACC_EN)
interface serial_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
`ifdef SERIAL_ADDSUB_ACC_EN
  logic             acc;
`endif
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDSUB_ACC_EN
  modport master (
    output start, a, b, sub, acc,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, sub, acc,
    output ready, busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, sub,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, sub,
    output ready, busy, done, sum, cout, ovf
  );
`endif
endinterface

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial adder/subtractor; SERIAL_ADDSUB_ACC_EN adds accumulate-from-sum mode
module serial_addsub #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [DIGIT:0]     digit_sum;
  logic [WIDTH-1:0]   sum_shift;
  logic [WIDTH-1:0]   a_src;
  logic               last_step;

  // One DIGIT-wide ripple slice over the low digits of the operand registers.
  assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry_q};

  // New result digit enters at the top, so after STEPS shifts the LSB digit
  // has travelled all the way down to bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_full_digit
      assign sum_shift = digit_sum[DIGIT-1:0];
    end else begin : g_part_digit
      assign sum_shift = {digit_sum[DIGIT-1:0], sum_q[WIDTH-1:DIGIT]};
    end
  endgenerate

`ifdef SERIAL_ADDSUB_ACC_EN
  assign a_src = bus.acc ? sum_q : bus.a;
`else
  assign a_src = bus.a;
`endif

  assign last_step = (cnt_q == CNT_W'(STEPS - 1));

  // State register and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state: accept in IDLE, one digit per cycle in RUN, flags on the last digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = a_src;
          // Subtraction as a + ~b + 1: the +1 rides in on the initial carry.
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sum_d   = sum_shift;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = digit_sum[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_step) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          cout_d  = digit_sum[DIGIT];
          // Operand MSBs are the top bits of the last digit still in the registers.
          ovf_d   = (a_q[DIGIT-1] == b_q[DIGIT-1])
                 && (digit_sum[DIGIT-1] != a_q[DIGIT-1]);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (vectors, corner sequences, random vs model)
module tb_serial_addsub;

  localparam int WIDTH = 32;
  localparam int DIGIT = 1;
  localparam int STEPS = WIDTH / DIGIT;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_addsub_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on whole operands.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] r, output logic c, output logic o);
    longint sa;
    longint sb;
    longint t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    t  = s ? (sa - sb) : (sa + sb);
    r  = s ? (a - b) : (a + b);
    c  = s ? (a >= b) : (({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF);
    o  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
  endfunction

  task automatic drive_idle();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sub   = 1'b0;
`ifdef SERIAL_ADDSUB_ACC_EN
    bus.acc   = 1'b0;
`endif
  endtask

  // Launch one op, check latency and results. poke>0 pulses start with junk
  // operands at that cycle of the run; check_drop verifies the done cycle ends.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input int acc,
                       input logic [31:0] es, input logic ec, input logic eo,
                       input int poke, input bit check_drop);
    int w;
    int lat;
    w = 0;
    while (!bus.ready && w < 4 * STEPS) begin
      @(posedge clk); #1;
      w++;
    end
    chk({name, "_ready"}, {31'd0, bus.ready}, 32'd1);
    bus.a     = a;
    bus.b     = b;
    bus.sub   = s;
`ifdef SERIAL_ADDSUB_ACC_EN
    bus.acc   = (acc != 0);
`else
    if (acc != 0) $display("note: acc ignored in this build");
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.sub   = ~s;
`ifdef SERIAL_ADDSUB_ACC_EN
    bus.acc   = 1'b0;
`endif
    chk({name, "_busy"}, {30'd0, bus.busy, bus.ready}, 32'd2);
    lat = 0;
    for (int k = 1; k <= STEPS + 4; k++) begin
      if (poke != 0 && k == poke) begin
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    bus.start = 1'b0;
    chk({name, "_latency"}, lat, STEPS);
    chk({name, "_sum"}, bus.sum, es);
    chk({name, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
    chk({name, "_ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
    if (check_drop) begin
      @(posedge clk); #1;
      chk({name, "_done_drop"}, {31'd0, bus.done}, 32'd0);
      chk({name, "_sum_hold"}, bus.sum, es);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, rs;
    logic        rsub, rc, ro;
    int          seen;

    checks = 0;
    errors = 0;

    vecs.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0000_0001, 1'b0, 1'b0});
    vecs.push_back('{32'h0000_0002, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1, 1'b0});
    vecs.push_back('{32'h0000_0002, 32'h0000_0002, 1'b1, 32'h0000_0000, 1'b1, 1'b0});
    vecs.push_back('{32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0});
    vecs.push_back('{32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFF, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1});
    vecs.push_back('{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0});
    vecs.push_back('{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b1, 1'b0});

    // Reset hold with start asserted: nothing may be accepted.
    drive_idle();
    bus.start = 1'b1;
    bus.a     = 32'h0000_0055;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, bus.ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sum", bus.sum, 32'd0);
    chk("rst_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_idle", {31'd0, bus.ready}, 32'd1);

    // Fixed vectors.
    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, 0,
            vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf, 0, 1'b1);
    end

    // start pulsed mid-run must not disturb the op in flight.
    model(32'h0000_1234, 32'h0000_0011, 1'b0, rs, rc, ro);
    do_op("midrun_ignore", 32'h0000_1234, 32'h0000_0011, 1'b0, 0, rs, rc, ro, 6, 1'b1);

    // Back-to-back: start in the done cycle is accepted, next done STEPS later.
    model(32'h0000_0100, 32'h0000_0001, 1'b1, rs, rc, ro);
    do_op("b2b_first", 32'h0000_0100, 32'h0000_0001, 1'b1, 0, rs, rc, ro, 0, 1'b0);
    model(32'h8000_0001, 32'h8000_0001, 1'b0, rs, rc, ro);
    do_op("b2b_second", 32'h8000_0001, 32'h8000_0001, 1'b0, 0, rs, rc, ro, 0, 1'b1);

    // Reset mid-op: abort, reset values, no done.
    bus.a     = 32'h0F0F_0F0F;
    bus.b     = 32'h0101_0101;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", {31'd0, bus.ready}, 32'd1);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_sum", bus.sum, 32'd0);
    chk("midrst_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < STEPS + 4; k++) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    model(32'h0000_0030, 32'h0000_0031, 1'b1, rs, rc, ro);
    do_op("after_rst", 32'h0000_0030, 32'h0000_0031, 1'b1, 0, rs, rc, ro, 0, 1'b1);

`ifdef SERIAL_ADDSUB_ACC_EN
    do_op("acc_load", 32'h0000_0000, 32'h0000_0005, 1'b0, 0, 32'd5, 1'b0, 1'b0, 0, 1'b1);
    do_op("acc_add", 32'hFFFF_0000, 32'h0000_0003, 1'b0, 1, 32'd8, 1'b0, 1'b0, 0, 1'b1);
    do_op("acc_sub", 32'hFFFF_0000, 32'h0000_0008, 1'b1, 1, 32'd0, 1'b1, 1'b0, 0, 1'b1);
`endif

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      rb   = (i % 5 == 0) ? ra : $urandom;
      rsub = 1'($urandom_range(0, 1));
      if (i % 7 == 3) ra[31] = ~rb[31];
      model(ra, rb, rsub, rs, rc, ro);
      do_op($sformatf("rnd%0d", i), ra, rb, rsub, 0, rs, rc, ro, 0, (i % 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Multi-cycle, bit-serial counterpart of the team's 32-bit combinational adder/subtractor.
- Accepts one operand pair per start pulse and walks DIGIT bits per cycle from LSB to MSB through a DIGIT-wide ripple slice.
- Returns sum, carry-out and signed overflow with a one-cycle done strobe.
- Sits beside the combinational unit as the area-lean path for datapaths that can tolerate WIDTH/DIGIT cycles of latency.

Parameters:
WIDTH, 32, operand/result width in bits
DIGIT, 1, bits processed per cycle; must divide WIDTH (STEPS = WIDTH/DIGIT)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
start  input  1  request; accepted only when ready=1
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
sub  input  1  0: a+b, 1: a-b; sampled on accept
ready  output  1  high in IDLE; equals !busy
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result, held until the next accept
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  two's-complement overflow

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: rst_n=0 sampled at a rising clk edge resets the block.
- Reset values: state=IDLE, busy=0, ready=1, done=0, sum=0, cout=0, ovf=0, internal step counter=0.
- States: IDLE, RUN.
- IDLE -> RUN on the edge where start=1.
  - Latch a into the A shift register.
  - Latch (sub ? ~b : b) into the B shift register.
  - Set carry register = sub.
  - Clear the counter.
- In RUN, on each edge:
  - Add the low DIGIT bits of the A and B registers plus the carry register.
  - Shift the DIGIT-bit result into the top of the sum register.
  - Shift the A and B registers right by DIGIT.
  - Update the carry register.
  - Increment the counter.
- Last step (counter = STEPS-1 at the edge): state -> IDLE, done=1 for exactly one cycle, cout = final carry.
  - ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the possibly-inverted B.
- Latency: start accepted at edge N gives done=1 and valid sum/cout/ovf from edge N+STEPS.
- start while busy=1 is ignored: no queuing, no effect on the operation in flight.
- start in the same cycle that done is high is accepted (the block is already IDLE). sum/cout/ovf stay stable until the next accept.
- sum is not guaranteed meaningful during RUN; consumers qualify it with done.
- Arithmetic is modulo 2^WIDTH; no saturation.
- done is cleared on the edge after it is asserted, unless reset clears it first.
- Reset mid-operation aborts immediately: all outputs return to their reset values, the partial result is discarded, and done is not asserted.
- Boundaries:
  - 0xFFFFFFFF + 0xFFFFFFFF = 0xFFFFFFFE, cout=1.
  - 0 - 1 = 0xFFFFFFFF, cout=0.
  - x - x = 0, cout=1.

Optional Feature:
- Macro: SERIAL_ADDSUB_ACC_EN.
- When defined: extra input port acc (1 bit), sampled on accept.
  - acc=1: operand A is taken from the current sum register instead of port a (running accumulate/decrement).
  - acc=0: normal behaviour.
  - After reset, an acc=1 accept uses A=0.
- When not defined: the acc port does not exist and A is always taken from port a.

Test Plan:
- Reset hold: rst_n=0 for 3 cycles with start=1 -> ready=1, busy=0, done=0, sum=0, no accept. Release, start a=1, b=0, sub=0 -> done at edge N+32 (DIGIT=1), sum=0x00000001, cout=0, ovf=0.
- Add/sub set: a=2,b=1,sub=1 -> 0x1, cout=1. a=2,b=2,sub=1 -> 0x0, cout=1. a=0xFFFF,b=1,sub=0 -> 0x10000. a=0x10000,b=1,sub=1 -> 0xFFFF. a=b=0xFFFFFFFF,sub=0 -> 0xFFFFFFFE, cout=1.
- Overflow: 0x7FFFFFFF+1 -> 0x80000000, ovf=1, cout=0. 0x80000000-1 -> 0x7FFFFFFF, ovf=1. 0-1 -> 0xFFFFFFFF, cout=0, ovf=0.
- Handshake: start pulsed mid-RUN with other operands -> ignored, result unchanged. Start asserted in the done cycle -> accepted, next done exactly STEPS cycles later.
- Reset mid-op: rst_n=0 at step 10 -> outputs at reset values, no done pulse. A new op after release completes correctly.
- DIGIT=4 and DIGIT=8 builds: same vectors -> identical results at latency 8 and 4 cycles. With SERIAL_ADDSUB_ACC_EN: accumulate 5, then acc=1 b=3 sub=0 -> sum=8, then acc=1 b=8 sub=1 -> sum=0.
